dmem_responder: RTL and testbench

- Responder end of the pipeline's memory-stage interface (M_input/M_output): a 16-word x 32-bit data memory.
- It services one LW/SW request at a time with a fixed multi-cycle access latency.
- It drives a stall back to the hazard/IF logic while an access is in flight.
- Sits behind the M stage; its read data feeds WB_input.mem.

---
 rtl/dmem_responder_pkg.sv | 27 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types for the memory-stage data memory responder
package dmem_responder_pkg;

  localparam int MemAddrWidth = 4;

  typedef logic [31:0] Register;

  typedef struct packed {
    Register addr;
    Register val;
  } MemData;

  typedef struct packed {
    logic   read;
    logic   write;
    MemData data;
  } M_input;

  typedef struct packed {
    Register val;
  } M_output;

  typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} MemState;

  typedef logic [MemAddrWidth-1:0] MemIndex;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: synchronous write, combinational read, cleared on reset
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 2**MemAddrWidth
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [MemAddrWidth-1:0] idx,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle LW/SW responder with stall; optional MEM_ADDR_CHECK_EN range check
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2**MemAddrWidth
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [65:0] m_in,
  output logic [31:0] m_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  M_input  req_in;
  MemState state;
  logic [3:0] cnt;
  logic    op_write;
  MemIndex idx;
  Register wdata;
  Register rdata;
  logic    oor;
  logic    in_oor;
  logic    req;
  logic    we;
  logic    unused_addr_bits;

  assign req_in = M_input'(m_in);
  assign req    = req_in.read | req_in.write;

`ifdef MEM_ADDR_CHECK_EN
  assign in_oor           = |req_in.data.addr[31:MemAddrWidth+2];
  assign unused_addr_bits = ^req_in.data.addr[1:0];
`else
  // Upper address bits alias onto the 16-word array.
  assign in_oor           = 1'b0;
  assign unused_addr_bits = ^{req_in.data.addr[31:MemAddrWidth+2], req_in.data.addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      oor      <= 1'b0;
      m_out    <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (req) begin
            op_write <= req_in.write;
            idx      <= req_in.data.addr[MemAddrWidth+1:2];
            wdata    <= req_in.data.val;
            oor      <= in_oor;
            cnt      <= CNT_INIT;
            state    <= MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          if (cnt == 4'd0) begin
            if (!op_write) m_out <= oor ? '0 : rdata;
            state <= MEM_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        MEM_DONE: state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  assign we = (state == MEM_BUSY) && (cnt == 4'd0) && op_write && !oor;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .idx   (idx),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Stall is combinational in IDLE so the pipeline freezes in the request cycle.
  assign stall = !reset && (((state == MEM_IDLE) && req) || (state == MEM_BUSY));
  assign done  = (state == MEM_DONE);

`ifdef MEM_ADDR_CHECK_EN
  assign err = done && oor;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (LATENCY=2)
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [65:0] m_in;
  logic [31:0] m_out;
  logic        stall;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_m [$];
  logic        sb_e [$];
  logic [31:0] exp_m;
  logic        exp_e;

  dmem_responder #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .m_in  (m_in),
    .m_out (m_out),
    .stall (stall),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request at %0t", $time);
      end else begin
        exp_m = sb_m.pop_front();
        exp_e = sb_e.pop_front();
        check("resp_m_out", m_out, exp_m);
        check("resp_err", 32'(err), 32'(exp_e));
      end
    end else if (err) begin
      checks++;
      errors++;
      $display("FAIL stray_err: got err=1 expected 0 outside done at %0t", $time);
    end
  end

  // Holds the request until done; the next call or idle() changes m_in after the DONE cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] val, input logic [31:0] em, input logic ee);
    int  n  = 0;
    int  st = 0;
    bit  seen = 0;
    sb_m.push_back(em);
    sb_e.push_back(ee);
    @(posedge clk);
    #1 m_in = {rd, wr, addr, val};
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check("stall_same_cycle", 32'(stall), 32'd1);
      if (stall) st++;
      if (done) seen = 1;
    end
    check("done_latency", n, LAT + 2);
    check("stall_cycles", st, LAT + 1);
    if (!seen) begin
      void'(sb_m.pop_back());
      void'(sb_e.pop_back());
    end
  endtask

  task automatic idle(input int cycles);
    @(posedge clk);
    #1 m_in = '0;
    repeat (cycles) begin
      @(negedge clk);
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_in  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (5) begin
      @(negedge clk);
      check("reset_m_out", m_out, 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      check("reset_done", 32'(done), 32'd0);
    end

    do_req(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);
    idle(3);

    do_req(1'b1, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 1'b1, 32'h04, 32'h5, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 1'b0, 32'h04, 32'h0, 32'h5, 1'b0);

    // Reset in the second BUSY cycle of a write: write must be dropped.
    @(posedge clk);
    #1 m_in = {1'b0, 1'b1, 32'h10, 32'hAA};
    @(negedge clk);
    check("rst_req_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 begin
      reset = 1'b1;
      m_in  = '0;
    end
    @(negedge clk);
    check("rst_forced_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_m_out", m_out, 32'd0);

    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);

`ifdef MEM_ADDR_CHECK_EN
    do_req(1'b0, 1'b1, 32'h48, 32'h1, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
`else
    do_req(1'b0, 1'b1, 32'h48, 32'h1, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h08, 32'h0, 32'h1, 1'b0);
`endif

    idle(3);
    check("scoreboard_empty", 32'(sb_m.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
